// File: rtl/tomasulo_exe.sv
// Fixed-latency pipelined integer execution unit feeding the CDB.
// Result is computed in the issue cycle and then delayed LATENCY_N-1 stages.
module tomasulo_exe #(
  parameter int unsigned LATENCY_N = 2,
  parameter int unsigned W         = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned ROBID_W   = 4,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned IMM_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           iss_vld_r,
  input  logic [3:0]                     iss_op,
  input  logic [W-1:0]                   iss_rdata0,
  input  logic [W-1:0]                   iss_rdata1,
  input  logic [IMM_W-1:0]               iss_imm,
  input  logic [TAG_W-1:0]               iss_tag,
  input  logic [ROBID_W-1:0]             iss_robid,
  input  logic [REG_W-1:0]               iss_wa,
  output logic                           cdb_vld_r,
  output logic [TAG_W-1:0]               cdb_tag_r,
  output logic [W-1:0]                   cdb_wdata_r,
  output logic [ROBID_W-1:0]             cdb_robid_r,
  output logic [REG_W-1:0]               cdb_wa_r,
  output logic                           cdb_err_r,
  output logic [$clog2(LATENCY_N+1)-1:0] inflight_r
);

  localparam int unsigned CW = $clog2(LATENCY_N + 1);
  localparam int unsigned PW = TAG_W + ROBID_W + REG_W + W;

  logic                 accept;
  logic                 illegal;
  logic [W-1:0]         imm_ext;
  logic [W-1:0]         res;
  logic [LATENCY_N-1:0] vld_q, vld_d;
  logic [LATENCY_N-1:0] err_q, err_d;
  logic [PW-1:0]        pl_q [LATENCY_N];
  logic [CW-1:0]        cnt_q, cnt_d;

  // An op presented in a flush cycle is dropped along with everything in flight.
  assign accept  = iss_vld_r & ~flush;
  assign imm_ext = {{(W - IMM_W){iss_imm[IMM_W-1]}}, iss_imm};

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (iss_op)
      4'd0:    res = iss_rdata0 + iss_rdata1;
      4'd1:    res = iss_rdata0 - iss_rdata1;
      4'd2:    res = iss_rdata0 & iss_rdata1;
      4'd3:    res = iss_rdata0 | iss_rdata1;
      4'd4:    res = iss_rdata0 ^ iss_rdata1;
      4'd5:    res = iss_rdata0 << iss_rdata1[4:0];
      4'd6:    res = iss_rdata0 >> iss_rdata1[4:0];
      4'd7:    res = iss_rdata0 + imm_ext;
      4'd8:    res = {{(W - 1){1'b0}}, ($signed(iss_rdata0) < $signed(iss_rdata1))};
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    vld_d[0] = accept;
    err_d[0] = accept & illegal;
    for (int k = 1; k < LATENCY_N; k++) begin
      vld_d[k] = vld_q[k-1] & ~flush;
      err_d[k] = err_q[k-1] & ~flush;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(accept) - CW'(vld_q[LATENCY_N-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload is unreset and only moves alongside a valid op.
  always_ff @(posedge clk) begin
    if (iss_vld_r) begin
      pl_q[0] <= {iss_tag, iss_robid, iss_wa, res};
    end
    for (int k = 1; k < LATENCY_N; k++) begin
      if (vld_q[k-1]) begin
        pl_q[k] <= pl_q[k-1];
      end
    end
  end

  assign cdb_vld_r  = vld_q[LATENCY_N-1];
  assign cdb_err_r  = err_q[LATENCY_N-1];
  assign inflight_r = cnt_q;
  assign {cdb_tag_r, cdb_robid_r, cdb_wa_r, cdb_wdata_r} = pl_q[LATENCY_N-1];

  a_inflight_max: assert property (@(posedge clk) disable iff (!rst)
    inflight_r <= CW'(LATENCY_N));
  a_err_qual: assert property (@(posedge clk) disable iff (!rst)
    !cdb_vld_r |-> !cdb_err_r);
  a_vld_known: assert property (@(posedge clk) disable iff (!rst)
    !$isunknown(cdb_vld_r));

endmodule

// File: tb/tb_tomasulo_exe.sv
// Directed bench for tomasulo_exe at LATENCY_N=2, W=32.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_tomasulo_exe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        iss_vld_r;
  logic [3:0]  iss_op;
  logic [31:0] iss_rdata0;
  logic [31:0] iss_rdata1;
  logic [15:0] iss_imm;
  logic [3:0]  iss_tag;
  logic [3:0]  iss_robid;
  logic [4:0]  iss_wa;
  logic        cdb_vld_r;
  logic [3:0]  cdb_tag_r;
  logic [31:0] cdb_wdata_r;
  logic [3:0]  cdb_robid_r;
  logic [4:0]  cdb_wa_r;
  logic        cdb_err_r;
  logic [1:0]  inflight_r;

  int n_chk  = 0;
  int n_fail = 0;

  tomasulo_exe #(
    .LATENCY_N (2),
    .W         (32),
    .TAG_W     (4),
    .ROBID_W   (4),
    .REG_W     (5),
    .IMM_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .iss_vld_r   (iss_vld_r),
    .iss_op      (iss_op),
    .iss_rdata0  (iss_rdata0),
    .iss_rdata1  (iss_rdata1),
    .iss_imm     (iss_imm),
    .iss_tag     (iss_tag),
    .iss_robid   (iss_robid),
    .iss_wa      (iss_wa),
    .cdb_vld_r   (cdb_vld_r),
    .cdb_tag_r   (cdb_tag_r),
    .cdb_wdata_r (cdb_wdata_r),
    .cdb_robid_r (cdb_robid_r),
    .cdb_wa_r    (cdb_wa_r),
    .cdb_err_r   (cdb_err_r),
    .inflight_r  (inflight_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic [3:0] tag,
                       input logic [3:0] robid, input logic [4:0] wa);
    iss_vld_r  = 1'b1;
    iss_op     = op;
    iss_rdata0 = a;
    iss_rdata1 = b;
    iss_imm    = imm;
    iss_tag    = tag;
    iss_robid  = robid;
    iss_wa     = wa;
  endtask

  task automatic idle();
    iss_vld_r  = 1'b0;
    iss_op     = 4'h0;
    iss_rdata0 = '0;
    iss_rdata1 = '0;
    iss_imm    = '0;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    iss_tag   = '0;
    iss_robid = '0;
    iss_wa    = '0;
    idle();
    #3;
    check_val("rst_vld", 32'(cdb_vld_r), 32'd0);
    check_val("rst_err", 32'(cdb_err_r), 32'd0);
    check_val("rst_inflight", 32'(inflight_r), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // 1: single ADD, two-cycle latency, one-cycle pulse
    issue(4'd0, 32'd5, 32'd7, 16'h0, 4'd3, 4'd9, 5'd4);
    step();
    idle();
    check_val("t1_c1_vld", 32'(cdb_vld_r), 32'd0);
    check_val("t1_c1_inflight", 32'(inflight_r), 32'd1);
    step();
    check_val("t1_vld", 32'(cdb_vld_r), 32'd1);
    check_val("t1_wdata", cdb_wdata_r, 32'd12);
    check_val("t1_tag", 32'(cdb_tag_r), 32'd3);
    check_val("t1_robid", 32'(cdb_robid_r), 32'd9);
    check_val("t1_wa", 32'(cdb_wa_r), 32'd4);
    check_val("t1_err", 32'(cdb_err_r), 32'd0);
    step();
    check_val("t1_c3_vld", 32'(cdb_vld_r), 32'd0);
    check_val("t1_c3_inflight", 32'(inflight_r), 32'd0);

    // 2: back-to-back SUB, SLL, SRL, ADDI
    issue(4'd1, 32'd0, 32'd1, 16'h0, 4'd1, 4'd1, 5'd1);
    step();
    issue(4'd5, 32'd1, 32'd31, 16'h0, 4'd2, 4'd2, 5'd2);
    step();
    check_val("t2_sub", cdb_wdata_r, 32'hFFFF_FFFF);
    check_val("t2_c2_inflight", 32'(inflight_r), 32'd2);
    issue(4'd6, 32'h8000_0000, 32'd31, 16'h0, 4'd3, 4'd3, 5'd3);
    step();
    check_val("t2_sll", cdb_wdata_r, 32'h8000_0000);
    check_val("t2_sll_tag", 32'(cdb_tag_r), 32'd2);
    check_val("t2_c3_inflight", 32'(inflight_r), 32'd2);
    issue(4'd7, 32'd10, 32'd0, 16'hFFFF, 4'd4, 4'd4, 5'd4);
    step();
    idle();
    check_val("t2_srl", cdb_wdata_r, 32'h0000_0001);
    check_val("t2_c4_inflight", 32'(inflight_r), 32'd2);
    step();
    check_val("t2_addi_vld", 32'(cdb_vld_r), 32'd1);
    check_val("t2_addi", cdb_wdata_r, 32'd9);
    check_val("t2_c5_inflight", 32'(inflight_r), 32'd1);
    step();
    check_val("t2_c6_vld", 32'(cdb_vld_r), 32'd0);

    // 3: signed compare, then logic ops
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 16'h0, 4'd5, 4'd5, 5'd5);
    step();
    issue(4'd8, 32'd1, 32'hFFFF_FFFF, 16'h0, 4'd6, 4'd6, 5'd6);
    step();
    check_val("t3_slt_neg", cdb_wdata_r, 32'd1);
    issue(4'd2, 32'hF0F0_1234, 32'h0FF0_00FF, 16'h0, 4'd7, 4'd7, 5'd7);
    step();
    check_val("t3_slt_pos", cdb_wdata_r, 32'd0);
    issue(4'd3, 32'hF0F0_1234, 32'h0FF0_00FF, 16'h0, 4'd8, 4'd8, 5'd8);
    step();
    check_val("t3_and", cdb_wdata_r, 32'h00F0_0034);
    issue(4'd4, 32'hF0F0_1234, 32'h0FF0_00FF, 16'h0, 4'd9, 4'd9, 5'd9);
    step();
    idle();
    check_val("t3_or", cdb_wdata_r, 32'hFFF0_12FF);
    step();
    check_val("t3_xor", cdb_wdata_r, 32'hFF00_12CB);
    step();

    // 4: flush kills both in-flight and same-cycle op
    issue(4'd0, 32'd3, 32'd4, 16'h0, 4'd1, 4'd1, 5'd1);
    step();
    issue(4'd0, 32'd5, 32'd5, 16'h0, 4'd2, 4'd2, 5'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("t4_c2_vld", 32'(cdb_vld_r), 32'd0);
    check_val("t4_c2_inflight", 32'(inflight_r), 32'd0);
    issue(4'd0, 32'd1, 32'd1, 16'h0, 4'd3, 4'd3, 5'd3);
    step();
    idle();
    check_val("t4_c3_vld", 32'(cdb_vld_r), 32'd0);
    step();
    check_val("t4_c4_vld", 32'(cdb_vld_r), 32'd1);
    check_val("t4_c4_wdata", cdb_wdata_r, 32'd2);
    step();

    // 5: illegal opcode still broadcasts, flagged
    issue(4'hF, 32'd5, 32'd5, 16'h0, 4'd7, 4'd2, 5'd2);
    step();
    idle();
    step();
    check_val("t5_vld", 32'(cdb_vld_r), 32'd1);
    check_val("t5_err", 32'(cdb_err_r), 32'd1);
    check_val("t5_wdata", cdb_wdata_r, 32'd0);
    check_val("t5_tag", 32'(cdb_tag_r), 32'd7);
    step();
    check_val("t5_err_clr", 32'(cdb_err_r), 32'd0);

    // 6: async reset mid-flight
    issue(4'd0, 32'd2, 32'd2, 16'h0, 4'd1, 4'd1, 5'd1);
    step();
    idle();
    #2 rst = 1'b0;
    #1;
    check_val("t6_rst_vld", 32'(cdb_vld_r), 32'd0);
    check_val("t6_rst_inflight", 32'(inflight_r), 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t6_no_bcast", 32'(cdb_vld_r), 32'd0);
    end
    issue(4'd0, 32'd8, 32'd9, 16'h0, 4'd5, 4'd5, 5'd5);
    step();
    idle();
    check_val("t6_post_c1", 32'(cdb_vld_r), 32'd0);
    step();
    check_val("t6_post_vld", 32'(cdb_vld_r), 32'd1);
    check_val("t6_post_wdata", cdb_wdata_r, 32'd17);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
